io_request_arbiter: RTL

//   Parametrised successor to the fixed-width core-to-IO arbiter: N cores share one
//   non-cacheable IO port. Fair round-robin grant, one transaction in flight,

---
 rtl/io_request_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/io_request_arbiter.sv
// Round-robin arbiter that lets N cores share one non-cacheable IO port.
// Only one transaction is in flight at a time, and each response is broadcast to all cores with the requester's tag.
module io_request_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int READ_LATENCY   = 1,
    localparam int CORE_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS-1:0]            req_store,
    input  logic [NUM_REQUESTERS*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic                                 rsp_valid,
    output logic [CORE_W-1:0]                    rsp_core,
    output logic [TAG_WIDTH-1:0]                 rsp_tag,
    output logic [DATA_WIDTH-1:0]                rsp_read_data,
    output logic                                 io_write_en,
    output logic                                 io_read_en,
    output logic [ADDR_WIDTH-1:0]                io_address,
    output logic [DATA_WIDTH-1:0]                io_write_data,
    input  logic [DATA_WIDTH-1:0]                io_read_data
);

    // Handshake: a request transfers in the cycle where req_valid[i] & req_ready[i];
    // req_ready is one-hot, only asserted in IDLE, and never while reset is high.

    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CORE_W:0]   N_EXT     = (CORE_W+1)'(NUM_REQUESTERS);
    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_REQUESTERS - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);

    generate
        if (READ_LATENCY < 1 || NUM_REQUESTERS < 1) begin : g_bad_param
            $error("io_request_arbiter: READ_LATENCY and NUM_REQUESTERS must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // Checkers bind to state; it is the single source of the transaction phase.
    state_t state;
    state_t state_next;

    logic [CORE_W-1:0]           rr_q;
    logic [LAT_W-1:0]            lat_cnt;
    logic                        store_q;
    logic [TAG_WIDTH-1:0]        tag_q;
    logic [CORE_W-1:0]           core_q;

    logic [2*NUM_REQUESTERS-1:0] req_dbl;
    logic [NUM_REQUESTERS-1:0]   req_rot;
    logic                        grant_found;
    logic [CORE_W:0]             grant_off;
    logic [CORE_W:0]             grant_sum;
    logic [CORE_W-1:0]           grant_idx;
    logic                        transfer;

    logic                        sel_store;
    logic [TAG_WIDTH-1:0]        sel_tag;
    logic [ADDR_WIDTH-1:0]       sel_addr;
    logic [DATA_WIDTH-1:0]       sel_data;

    // Rotating the doubled vector puts the pointer's core at bit 0, so the
    // lowest set bit is the first requester at or after the pointer.
    assign req_dbl = {req_valid, req_valid};
    assign req_rot = NUM_REQUESTERS'(req_dbl >> rr_q);

    always_comb begin
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!grant_found && req_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = (CORE_W+1)'(k);
            end
        end
        grant_sum = {1'b0, rr_q} + grant_off;
        grant_idx = (grant_sum >= N_EXT) ? CORE_W'(grant_sum - N_EXT) : CORE_W'(grant_sum);
    end

    assign transfer = (state == ST_IDLE) && !reset && grant_found;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready = NUM_REQUESTERS'(1) << grant_idx;
        end
    end

    always_comb begin
        sel_store = 1'b0;
        sel_tag   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (grant_idx == CORE_W'(k)) begin
                sel_store = req_store[k];
                sel_tag   = req_tag[k*TAG_WIDTH +: TAG_WIDTH];
                sel_addr  = req_address[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = req_write_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        io_write_en = 1'b0;
        io_read_en  = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (transfer) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                io_write_en = store_q;
                io_read_en  = !store_q;
                state_next  = store_q ? ST_RESPOND : ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_ONE) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Response fields load on the edge entering RESPOND, so they stay stable
    // from the pulse until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q          <= '0;
            lat_cnt       <= '0;
            store_q       <= 1'b0;
            tag_q         <= '0;
            core_q        <= '0;
            io_address    <= '0;
            io_write_data <= '0;
            rsp_core      <= '0;
            rsp_tag       <= '0;
            rsp_read_data <= '0;
        end else begin
            if (transfer) begin
                store_q       <= sel_store;
                tag_q         <= sel_tag;
                core_q        <= grant_idx;
                io_address    <= sel_addr;
                io_write_data <= sel_data;
                rr_q          <= (grant_idx == LAST_CORE) ? '0 : grant_idx + 1'b1;
            end
            case (state)
                ST_ISSUE: begin
                    if (store_q) begin
                        rsp_core      <= core_q;
                        rsp_tag       <= tag_q;
                        rsp_read_data <= '0;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_ONE) begin
                        rsp_core      <= core_q;
                        rsp_tag       <= tag_q;
                        rsp_read_data <= io_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
